// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Holds the datapath/opcode widths, register-address constants, the ALU
// opcode encodings carried through the pipeline, the ID/EX occupancy
// states and a small source-match helper used by hazard detection.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // True when an enabled source register reads the given destination.
  function automatic logic src_reads(input logic                  en,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst);
    return en && (src == dst);
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector for the ID/EX boundary (purely combinational).
// Ports:
//   ex_valid, ex_mem_rd, ex_rd_wen, ex_rd_addr : instruction held in EX
//   id_rs1_en/addr, id_rs2_en/addr             : sources of the decode instruction
//   hazard                                     : decode must wait one cycle
module id_ex_hazard
  import riscv_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_rd,
  input  logic                  ex_rd_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_rs1_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic                  hazard
);

  logic ex_is_load_wr;
  logic src_hit;

  always_comb begin
    ex_is_load_wr = ex_valid && ex_mem_rd && ex_rd_wen && (ex_rd_addr != REG_ZERO);
    src_hit       = src_reads(id_rs1_en, id_rs1_addr, ex_rd_addr) ||
                    src_reads(id_rs2_en, id_rs2_addr, ex_rd_addr);
    hazard        = ex_is_load_wr && src_hit;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand capture, write-through bypass,
// load-use stall and flush.
// Ports:
//   clk, rst (sync, active-high)
//   id_*      : decode instruction + valid/ready handshake
//   rf_r_data*: combinational register file read data
//   wb_*      : writeback port (also bypassed into captured/held operands)
//   flush     : kill EX contents and the decode instruction
//   ex_ready  : execute accepts the EX instruction
//   ex_*      : registered EX payload and valid
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter int unsigned ALU_OP_W = riscv_pkg::ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_rs1_en,
  input  logic                id_rs2_en,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic [4:0]          id_rd_addr,
  input  logic                id_rd_wen,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [2:0]          id_funct3,
  input  logic                id_mem_rd,
  input  logic                id_mem_wr,
  input  logic [XLEN-1:0]     rf_r_data1,
  input  logic [XLEN-1:0]     rf_r_data2,
  input  logic                wb_w_en,
  input  logic [4:0]          wb_w_addr,
  input  logic [XLEN-1:0]     wb_w_data,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_imm,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [4:0]          ex_rs1_addr,
  output logic [4:0]          ex_rs2_addr,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_rd_wen,
  output logic                ex_mem_rd,
  output logic                ex_mem_wr,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [2:0]          ex_funct3
);

  stage_state_e state_q, state_d;
  logic         hazard;
  logic         load;
  logic         hold_fwd;
  logic [XLEN-1:0] rs1_op, rs2_op;

  // x0 or a disabled source reads zero; a same-cycle writeback wins over
  // the register file since the file updates only at the edge.
  function automatic logic [XLEN-1:0] capture_operand(input logic            en,
                                                      input logic [4:0]      addr,
                                                      input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] op;
    op = rf_data;
    if (!en || addr == REG_ZERO) begin
      op = '0;
    end else if (wb_w_en && wb_w_addr == addr) begin
      op = wb_w_data;
    end
    return op;
  endfunction

  id_ex_hazard u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_rd   (ex_mem_rd),
    .ex_rd_wen   (ex_rd_wen),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_en   (id_rs1_en),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_en   (id_rs2_en),
    .id_rs2_addr (id_rs2_addr),
    .hazard      (hazard)
  );

  assign ex_valid = (state_q == ST_FULL);

  // A flush accepts (and drops) the decode instruction unconditionally.
  assign id_ready = !rst && (flush || ((!ex_valid || ex_ready) && !hazard));

  always_comb begin
    rs1_op = capture_operand(id_rs1_en, id_rs1_addr, rf_r_data1);
    rs2_op = capture_operand(id_rs2_en, id_rs2_addr, rf_r_data2);
  end

  // The load-use bubble needs no branch of its own: with a hazard id_ready
  // is low, so a FULL stage with ex_ready drains exactly like the no-load
  // case, and without ex_ready it holds.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    hold_fwd = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (id_valid && id_ready) begin
      load    = 1'b1;
      state_d = ST_FULL;
    end else if (state_q == ST_FULL) begin
      if (ex_ready) begin
        state_d = ST_EMPTY;
      end else begin
        hold_fwd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_rd_wen   <= 1'b0;
      ex_mem_rd   <= 1'b0;
      ex_mem_wr   <= 1'b0;
      ex_alu_op   <= '0;
      ex_funct3   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ex_pc       <= id_pc;
        ex_imm      <= id_imm;
        ex_rs1_data <= rs1_op;
        ex_rs2_data <= rs2_op;
        ex_rs1_addr <= id_rs1_en ? id_rs1_addr : REG_ZERO;
        ex_rs2_addr <= id_rs2_en ? id_rs2_addr : REG_ZERO;
        ex_rd_addr  <= id_rd_addr;
        ex_rd_wen   <= id_rd_wen;
        ex_mem_rd   <= id_mem_rd;
        ex_mem_wr   <= id_mem_wr;
        ex_alu_op   <= id_alu_op;
        ex_funct3   <= id_funct3;
      end else if (hold_fwd) begin
        // A stalled instruction must still observe writebacks that land
        // while it waits, or it would execute with stale operands.
        if (wb_w_en && wb_w_addr != REG_ZERO && wb_w_addr == ex_rs1_addr) begin
          ex_rs1_data <= wb_w_data;
        end
        if (wb_w_en && wb_w_addr != REG_ZERO && wb_w_addr == ex_rs2_addr) begin
          ex_rs2_data <= wb_w_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid;
  logic                id_ready;
  logic [31:0]         id_pc, id_imm;
  logic                id_rs1_en, id_rs2_en;
  logic [4:0]          id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic                id_rd_wen;
  logic [3:0]          id_alu_op;
  logic [2:0]          id_funct3;
  logic                id_mem_rd, id_mem_wr;
  logic [31:0]         rf_r_data1, rf_r_data2;
  logic                wb_w_en;
  logic [4:0]          wb_w_addr;
  logic [31:0]         wb_w_data;
  logic                flush;
  logic                ex_ready;
  logic                ex_valid;
  logic [31:0]         ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]          ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic                ex_rd_wen, ex_mem_rd, ex_mem_wr;
  logic [3:0]          ex_alu_op;
  logic [2:0]          ex_funct3;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3),
    .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .wb_w_en(wb_w_en), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_imm = '0;
    id_rs1_en = 0; id_rs2_en = 0; id_rs1_addr = '0; id_rs2_addr = '0;
    id_rd_addr = '0; id_rd_wen = 0; id_alu_op = '0; id_funct3 = '0;
    id_mem_rd = 0; id_mem_wr = 0;
    rf_r_data1 = '0; rf_r_data2 = '0;
    wb_w_en = 0; wb_w_addr = '0; wb_w_data = '0;
    flush = 0; ex_ready = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;

    // Reset state
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_rs1_data", ex_rs1_data, 0);
    chk("rst_ex_rd_addr", ex_rd_addr, 0);
    chk("rst_id_ready", id_ready, 0);

    // Basic capture from the register file, rs2 disabled
    rst = 0;
    id_valid = 1; id_pc = 32'h100; id_imm = 32'h4;
    id_rs1_en = 1; id_rs1_addr = 5; id_rs2_en = 0; id_rs2_addr = 6;
    id_rd_addr = 8; id_rd_wen = 1; id_alu_op = ALU_SLT; id_funct3 = 3'd2;
    rf_r_data1 = 32'h11; rf_r_data2 = 32'h99;
    settle();
    chk("basic_id_ready", id_ready, 1);
    tick();
    chk("basic_ex_valid", ex_valid, 1);
    chk("basic_rs1_data", ex_rs1_data, 32'h11);
    chk("basic_rs1_addr", ex_rs1_addr, 5);
    chk("basic_rs2_data_dis", ex_rs2_data, 0);
    chk("basic_rs2_addr_dis", ex_rs2_addr, 0);
    chk("basic_pc", ex_pc, 32'h100);
    chk("basic_imm", ex_imm, 32'h4);
    chk("basic_rd", ex_rd_addr, 8);
    chk("basic_alu_op", ex_alu_op, ALU_SLT);
    chk("basic_funct3", ex_funct3, 2);

    // Write-through bypass on rs2
    id_pc = 32'h104; id_rs1_en = 0; id_rs1_addr = 5;
    id_rs2_en = 1; id_rs2_addr = 7; rf_r_data2 = '0;
    wb_w_en = 1; wb_w_addr = 7; wb_w_data = 32'hDEADBEEF;
    tick();
    chk("byp_rs2_data", ex_rs2_data, 32'hDEADBEEF);
    chk("byp_rs1_addr_dis", ex_rs1_addr, 0);
    chk("byp_rs1_data_dis", ex_rs1_data, 0);

    // x0 source reads zero even with a writeback to x0
    id_pc = 32'h108; id_rs2_addr = 0; rf_r_data2 = 32'h55;
    wb_w_addr = 0;
    tick();
    chk("x0_rs2_data", ex_rs2_data, 0);
    chk("x0_pc", ex_pc, 32'h108);

    // Writeback to a different register does not bypass
    id_pc = 32'h10C; id_rs1_en = 1; id_rs1_addr = 4; rf_r_data1 = 32'h33;
    id_rs2_en = 0; wb_w_addr = 5; wb_w_data = 32'h77;
    tick();
    chk("nobyp_rs1_data", ex_rs1_data, 32'h33);

    // Load-use: load to x3 in EX, decode reads x3
    wb_w_en = 0;
    id_pc = 32'h200; id_rs1_addr = 1; rf_r_data1 = 32'h10;
    id_rd_addr = 3; id_rd_wen = 1; id_mem_rd = 1; id_alu_op = ALU_ADD;
    tick();
    chk("ld_ex_mem_rd", ex_mem_rd, 1);
    id_pc = 32'h204; id_rs1_addr = 3; rf_r_data1 = 32'hAB;
    id_rd_addr = 12; id_mem_rd = 0;
    settle();
    chk("hz_id_ready", id_ready, 0);
    tick();
    chk("hz_bubble_valid", ex_valid, 0);
    chk("hz_bubble_pc_kept", ex_pc, 32'h200);
    settle();
    chk("hz_id_ready_after", id_ready, 1);
    tick();
    chk("hz_enter_valid", ex_valid, 1);
    chk("hz_enter_pc", ex_pc, 32'h204);
    chk("hz_enter_rs1", ex_rs1_data, 32'hAB);

    // Stall three cycles with writebacks into held operands
    id_pc = 32'h300; id_rs1_addr = 9; rf_r_data1 = 32'h5;
    id_rs2_en = 1; id_rs2_addr = 10; rf_r_data2 = 32'h6;
    id_rd_addr = 11; id_alu_op = ALU_SRA;
    tick();
    chk("st_load_rs1", ex_rs1_data, 32'h5);
    ex_ready = 0;
    id_pc = 32'h400; rf_r_data1 = 32'h1; rf_r_data2 = 32'h2;
    wb_w_en = 1; wb_w_addr = 9; wb_w_data = 32'h42;
    settle();
    chk("st1_id_ready", id_ready, 0);
    tick();
    chk("st1_rs1_data", ex_rs1_data, 32'h42);
    chk("st1_rs2_data", ex_rs2_data, 32'h6);
    chk("st1_rs1_addr", ex_rs1_addr, 9);
    chk("st1_pc", ex_pc, 32'h300);
    wb_w_en = 0;
    settle();
    chk("st2_id_ready", id_ready, 0);
    tick();
    chk("st2_valid", ex_valid, 1);
    chk("st2_rs1_data", ex_rs1_data, 32'h42);
    wb_w_en = 1; wb_w_addr = 10; wb_w_data = 32'h66;
    settle();
    chk("st3_id_ready", id_ready, 0);
    tick();
    chk("st3_rs2_data", ex_rs2_data, 32'h66);
    chk("st3_alu_op", ex_alu_op, ALU_SRA);
    chk("st3_rd", ex_rd_addr, 11);
    chk("st3_pc", ex_pc, 32'h300);

    // Flush while FULL and stalled with a decode instruction pending
    wb_w_en = 0; flush = 1;
    settle();
    chk("fl_id_ready", id_ready, 1);
    tick();
    chk("fl_valid", ex_valid, 0);
    chk("fl_pc_kept", ex_pc, 32'h300);
    flush = 0;

    // Reset in the middle of a stall beats flush
    id_pc = 32'h500; id_imm = 32'hFFFF_FFF0;
    tick();
    chk("rs_loaded", ex_valid, 1);
    rst = 1; flush = 1;
    settle();
    chk("rs_id_ready", id_ready, 0);
    tick();
    chk("rs_valid", ex_valid, 0);
    chk("rs_pc", ex_pc, 0);
    chk("rs_imm", ex_imm, 0);
    chk("rs_rs1_data", ex_rs1_data, 0);
    chk("rs_rs2_addr", ex_rs2_addr, 0);
    chk("rs_rd_wen", ex_rd_wen, 0);
    chk("rs_alu_op", ex_alu_op, 0);
    rst = 0; flush = 0; ex_ready = 1;

    // Drain with no new instruction
    id_pc = 32'h600;
    tick();
    chk("dr_loaded", ex_pc, 32'h600);
    id_valid = 0;
    tick();
    chk("dr_valid", ex_valid, 0);
    chk("dr_pc_kept", ex_pc, 32'h600);

    // A load to x0 never causes a stall
    id_valid = 1; id_pc = 32'h700; id_rd_addr = 0; id_mem_rd = 1;
    tick();
    id_pc = 32'h704; id_rs1_en = 1; id_rs1_addr = 0; id_mem_rd = 0;
    settle();
    chk("x0ld_id_ready", id_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
